vga_axil_regs: RTL
==================

# vga_axil_regs

AXI4-Lite slave register file for the VGA subsystem: it terminates the AXI4-Lite bus driven by the host or bench master and exposes control and status registers to the VGA timing/pixel core. It sits directly downstream of the AXI4-Lite bus signal bundle and directly upstream of the VGA core. Reads and writes are single-beat, in order, with one outstanding transaction per direction.

## Interface
- AXIL_ADDR_W, 32: address width (`vga_axil_pkg::axil_addr_t`).
- AXIL_DATA_W, 32: data width (`vga_axil_pkg::axil_data_t`); wstrb width AXIL_DATA_W/8.
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready: AXI4-Lite write channels; slave directions per AXI4-Lite.
- araddr/arvalid/arready, rdata/rresp/rvalid/rready: AXI4-Lite read channels; slave directions per AXI4-Lite.
- frame_done  in  1  one-cycle pulse from the VGA core at end of frame.
- ctrl_en  out  1  VGA output enable (CTRL[0]).
- ctrl_test_pat  out  1  test-pattern select (CTRL[1]).
- bg_color  out  12  RGB444 background (BG[11:0]).
- irq  out  1  high while IRQ[0] == 1 and CTRL[2] == 1.

## Operation
- Map (word offsets, addr[1:0] ignored): 0x00 CTRL RW bits [2:0]; 0x04 BG RW bits [11:0]; 0x08 FRAME_CNT RO 32-bit; 0x0C IRQ W1C bit [0]. Unimplemented bits read 0.
- Decode: address valid iff addr[AXIL_ADDR_W-1:4] == 0. Invalid address or write to FRAME_CNT -> SLVERR, no state change, rdata 0. All others -> OKAY.
- Writes honour wstrb per byte; strobe 0 leaves the byte unchanged. IRQ: bit0 cleared when wstrb[0] && wdata[0].
- FRAME_CNT increments on every frame_done, wraps 0xFFFF_FFFF -> 0.
- IRQ[0] set on frame_done; set wins over a simultaneous W1C clear.
- Write path: AW and W accepted independently into holding registers (aw_held, w_held). awready = !aw_held && !bvalid; wready = !w_held && !bvalid. Commit when aw_held && w_held && !bvalid: update register, set bvalid/bresp, clear both held flags. bvalid held until bready.
- Read path: arready = !rvalid. On AR handshake, register rdata/rresp and set rvalid; held stable until rready.
- Read of FRAME_CNT returns value at the AR handshake edge (pre-increment if frame_done coincides).

## Timing
- Reset values: awready=1, wready=1, arready=1, bvalid=0, rvalid=0, bresp=OKAY, rresp=OKAY, rdata=0; CTRL=0, BG=0, FRAME_CNT=0, IRQ=0, so ctrl_en=0, ctrl_test_pat=0, bg_color=0, irq=0.
- Write latency: AW and W handshake in cycle N -> register updated and bvalid high in cycle N+2. If AW at N and W at M>N -> bvalid at M+2.
- Read latency: AR handshake in cycle N -> rvalid in N+1. Back-to-back reads: arready low until rvalid&&rready, so max one read per 2 cycles.
- Register outputs change the cycle after commit; irq is combinational from registered bits.
- Reset mid-transaction: held flags, bvalid, and rvalid are dropped with no response; the master is also reset.
- Read and write to the same register in the same cycle: the read returns the old value.

## Structure
- Add to `vga_axil_pkg`: register offset localparams (CTRL_OFS, BG_OFS, FRAME_CNT_OFS, IRQ_OFS) and CTRL bit index constants. Reuse the existing axil_resp_e.
- Single module; no sub-module. The byte-strobe merge is a package function `apply_wstrb(old, new, strb)`.

## Test plan
- Reset, then read 0x00/0x04/0x08/0x0C -> all 0, OKAY; all outputs 0.
- Write 0x04 = 0x0000_0ABC, strb 4'b0011 -> B OKAY; bg_color = 0xABC. Then strb 4'b0001 with 0x0000_0FFF -> bg_color = 0xAFF.
- AW at cycle 0 and W delayed 3 cycles, bready held low 2 cycles -> wready/awready low while held, bvalid stable, single write committed.
- 5 frame_done pulses -> FRAME_CNT reads 5; IRQ reads 1; with CTRL=0x4, irq=1. Write IRQ=1 in the same cycle as frame_done -> IRQ stays 1.
- Write 0x08 and read/write 0x10 -> SLVERR, FRAME_CNT unchanged, rdata 0.
- Read with rready low 4 cycles while frame_done pulses -> rdata stable, arready low until rready.

Source files
------------

// File: rtl/vga_axil_pkg.sv
// +----------------------------------------------------------------------+
// | vga_axil_pkg                                                          |
// | Shared AXI4-Lite types and the VGA register map definitions.          |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package vga_axil_pkg;

  localparam int AXIL_ADDR_W = 32;
  localparam int AXIL_DATA_W = 32;
  localparam int AXIL_STRB_W = AXIL_DATA_W / 8;

  typedef logic [AXIL_ADDR_W-1:0] axil_addr_t;
  typedef logic [AXIL_DATA_W-1:0] axil_data_t;
  typedef logic [AXIL_STRB_W-1:0] axil_strb_t;

  typedef enum logic [1:0] {
    AXIL_RESP_OKAY   = 2'b00,
    AXIL_RESP_EXOKAY = 2'b01,
    AXIL_RESP_SLVERR = 2'b10,
    AXIL_RESP_DECERR = 2'b11
  } axil_resp_e;

  // Byte offsets; decode uses bits [3:2] only.
  localparam logic [3:0] CTRL_OFS      = 4'h0;
  localparam logic [3:0] BG_OFS        = 4'h4;
  localparam logic [3:0] FRAME_CNT_OFS = 4'h8;
  localparam logic [3:0] IRQ_OFS       = 4'hC;

  localparam int CTRL_EN_BIT       = 0;
  localparam int CTRL_TEST_PAT_BIT = 1;
  localparam int CTRL_IRQ_EN_BIT   = 2;

  function automatic axil_data_t apply_wstrb(input axil_data_t old_val,
                                             input axil_data_t new_val,
                                             input axil_strb_t strb);
    axil_data_t merged;
    merged = old_val;
    for (int b = 0; b < AXIL_STRB_W; b++) begin
      if (strb[b]) merged[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_axil_regs.sv
// +----------------------------------------------------------------------+
// | vga_axil_regs                                                         |
// | AXI4-Lite slave exposing VGA control/status registers.                |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module vga_axil_regs
  import vga_axil_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [AXIL_ADDR_W-1:0] i_awaddr,
  input  logic                   i_awvalid,
  output logic                   o_awready,
  input  logic [AXIL_DATA_W-1:0] i_wdata,
  input  logic [AXIL_STRB_W-1:0] i_wstrb,
  input  logic                   i_wvalid,
  output logic                   o_wready,
  output logic [1:0]             o_bresp,
  output logic                   o_bvalid,
  input  logic                   i_bready,
  input  logic [AXIL_ADDR_W-1:0] i_araddr,
  input  logic                   i_arvalid,
  output logic                   o_arready,
  output logic [AXIL_DATA_W-1:0] o_rdata,
  output logic [1:0]             o_rresp,
  output logic                   o_rvalid,
  input  logic                   i_rready,
  input  logic                   i_frame_done,
  output logic                   o_ctrl_en,
  output logic                   o_ctrl_test_pat,
  output logic [11:0]            o_bg_color,
  output logic                   o_irq
);

  logic       r_aw_held, r_w_held, r_bvalid, r_rvalid;
  axil_addr_t r_awaddr;
  axil_data_t r_wdata, r_rdata, r_frame_cnt;
  axil_strb_t r_wstrb;
  axil_resp_e r_bresp, r_rresp;
  logic [2:0] r_ctrl;
  logic [11:0] r_bg;
  logic       r_irq;

  logic       w_awready, w_wready, w_arready, w_commit;
  logic       w_wr_addr_ok, w_wr_ok, w_rd_addr_ok;
  logic [1:0] w_wr_sel;
  axil_data_t w_ctrl_new, w_bg_new, w_rd_data;
  logic       w_irq_clr;
  logic       w_unused;

  assign w_awready = !r_aw_held && !r_bvalid;
  assign w_wready  = !r_w_held && !r_bvalid;
  assign w_arready = !r_rvalid;
  assign w_commit  = r_aw_held && r_w_held && !r_bvalid;

  assign w_wr_addr_ok = (r_awaddr[AXIL_ADDR_W-1:4] == '0);
  assign w_wr_sel     = r_awaddr[3:2];
  // FRAME_CNT is read-only, so a write there is rejected like a bad address.
  assign w_wr_ok      = w_wr_addr_ok && (w_wr_sel != FRAME_CNT_OFS[3:2]);
  assign w_rd_addr_ok = (i_araddr[AXIL_ADDR_W-1:4] == '0);

  assign w_ctrl_new = apply_wstrb({29'd0, r_ctrl}, r_wdata, r_wstrb);
  assign w_bg_new   = apply_wstrb({20'd0, r_bg}, r_wdata, r_wstrb);
  assign w_irq_clr  = w_commit && w_wr_ok && (w_wr_sel == IRQ_OFS[3:2])
                      && r_wstrb[0] && r_wdata[0];

  always_comb begin
    w_rd_data = '0;
    if (w_rd_addr_ok) begin
      case (i_araddr[3:2])
        CTRL_OFS[3:2]:      w_rd_data = {29'd0, r_ctrl};
        BG_OFS[3:2]:        w_rd_data = {20'd0, r_bg};
        FRAME_CNT_OFS[3:2]: w_rd_data = r_frame_cnt;
        default:            w_rd_data = {31'd0, r_irq};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_aw_held   <= 1'b0;
      r_w_held    <= 1'b0;
      r_awaddr    <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_bvalid    <= 1'b0;
      r_bresp     <= AXIL_RESP_OKAY;
      r_rvalid    <= 1'b0;
      r_rdata     <= '0;
      r_rresp     <= AXIL_RESP_OKAY;
      r_ctrl      <= '0;
      r_bg        <= '0;
      r_frame_cnt <= '0;
      r_irq       <= 1'b0;
    end else begin
      if (i_awvalid && w_awready) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= i_awaddr;
      end
      if (i_wvalid && w_wready) begin
        r_w_held <= 1'b1;
        r_wdata  <= i_wdata;
        r_wstrb  <= i_wstrb;
      end

      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_wr_ok ? AXIL_RESP_OKAY : AXIL_RESP_SLVERR;
        if (w_wr_ok && w_wr_sel == CTRL_OFS[3:2]) r_ctrl <= w_ctrl_new[2:0];
        if (w_wr_ok && w_wr_sel == BG_OFS[3:2])   r_bg   <= w_bg_new[11:0];
      end else if (r_bvalid && i_bready) begin
        r_bvalid <= 1'b0;
      end

      if (i_frame_done) r_frame_cnt <= r_frame_cnt + 1'b1;

      // A new frame event takes priority over a concurrent W1C.
      if (i_frame_done)   r_irq <= 1'b1;
      else if (w_irq_clr) r_irq <= 1'b0;

      if (i_arvalid && w_arready) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_data;
        r_rresp  <= w_rd_addr_ok ? AXIL_RESP_OKAY : AXIL_RESP_SLVERR;
      end else if (r_rvalid && i_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign o_awready       = w_awready;
  assign o_wready        = w_wready;
  assign o_arready       = w_arready;
  assign o_bvalid        = r_bvalid;
  assign o_bresp         = r_bresp;
  assign o_rvalid        = r_rvalid;
  assign o_rdata         = r_rdata;
  assign o_rresp         = r_rresp;
  assign o_ctrl_en       = r_ctrl[CTRL_EN_BIT];
  assign o_ctrl_test_pat = r_ctrl[CTRL_TEST_PAT_BIT];
  assign o_bg_color      = r_bg;
  assign o_irq           = r_irq && r_ctrl[CTRL_IRQ_EN_BIT];

  assign w_unused = ^{i_araddr[1:0], r_awaddr[1:0], w_ctrl_new[31:3], w_bg_new[31:12]};

endmodule

`default_nettype wire
